// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer: FSM state encoding and
// the saturating completed-period counter.
`timescale 1ns/1ps
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int                PCNT_W   = 4;
  localparam logic [PCNT_W-1:0] PCNT_MAX = 4'd15;

  function automatic logic [PCNT_W-1:0] pcnt_inc(input logic [PCNT_W-1:0] c);
    return (c == PCNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// DIV-modulo enable counter; tick is high for the enabled cycle that wraps it.
// Combinational tick from registered count, no backpressure; clr wins over en.
`timescale 1ns/1ps
module tick_prescaler #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == LAST);
  assign tick    = en && at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Sequenced up-counter: start/stop/hold control, prescaled ticks, done pulse on terminal.
// All outputs registered (terminal at (limit+1)*DIV run cycles); PERIODIC_EN enables auto-restart.
`timescale 1ns/1ps
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic [WIDTH-1:0]  limit,
  input  logic              periodic,
  output logic [WIDTH-1:0]  q,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] period_cnt
);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic               done_nxt;
  logic [PCNT_W-1:0]  pcnt_r, pcnt_nxt;
  logic [WIDTH-1:0]   limit_r, limit_nxt;
  logic               per_r, per_nxt;
  logic               periodic_in;
  logic               pre_clr;
  logic               run_en;
  logic               tick;

`ifdef PERIODIC_EN
  assign periodic_in = periodic;
  assign period_cnt  = pcnt_r;
`else
  logic unused_periodic;
  assign unused_periodic = periodic;
  assign periodic_in     = 1'b0;
  assign period_cnt      = '0;
`endif

  // PAUSE with hold released already counts, so each hold cycle costs exactly one cycle.
  assign run_en = (state != IDLE) && !stop && !hold;
  assign busy   = (state != IDLE);

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (run_en),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    done_nxt  = 1'b0;
    pcnt_nxt  = pcnt_r;
    limit_nxt = limit_r;
    per_nxt   = per_r;
    pre_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
          q_nxt     = '0;
          pre_clr   = 1'b1;
          pcnt_nxt  = '0;
          limit_nxt = limit;
          per_nxt   = periodic_in;
        end
      end
      RUN, PAUSE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (hold) begin
          state_nxt = PAUSE;
        end else begin
          state_nxt = RUN;
          if (tick) begin
            if (q == limit_r) begin
              done_nxt = 1'b1;
              pcnt_nxt = pcnt_inc(pcnt_r);
              if (per_r) q_nxt = '0;
              else       state_nxt = IDLE;
            end else begin
              q_nxt = q + 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      q       <= '0;
      done    <= 1'b0;
      pcnt_r  <= '0;
      limit_r <= '0;
      per_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      q       <= q_nxt;
      done    <= done_nxt;
      pcnt_r  <= pcnt_nxt;
      limit_r <= limit_nxt;
      per_r   <= per_nxt;
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer at DIV=2/1/3; expected outputs are queued per edge and
// compared at the following negedge.
`timescale 1ns/1ps
module tb_count_sequencer;

  localparam int W = 4;
`ifdef PERIODIC_EN
  localparam bit PC_ON = 1'b1;
`else
  localparam bit PC_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         st[3], sp[3], hd[3], per[3];
  logic [W-1:0] lim[3];
  logic [W-1:0] qo[3];
  logic         bz[3], dn[3];
  logic [3:0]   pc[3];

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(W), .DIV(2)) u_d2 (
    .clk(clk), .rst(rst), .start(st[0]), .stop(sp[0]), .hold(hd[0]), .limit(lim[0]),
    .periodic(per[0]), .q(qo[0]), .busy(bz[0]), .done(dn[0]), .period_cnt(pc[0]));
  count_sequencer #(.WIDTH(W), .DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .start(st[1]), .stop(sp[1]), .hold(hd[1]), .limit(lim[1]),
    .periodic(per[1]), .q(qo[1]), .busy(bz[1]), .done(dn[1]), .period_cnt(pc[1]));
  count_sequencer #(.WIDTH(W), .DIV(3)) u_d3 (
    .clk(clk), .rst(rst), .start(st[2]), .stop(sp[2]), .hold(hd[2]), .limit(lim[2]),
    .periodic(per[2]), .q(qo[2]), .busy(bz[2]), .done(dn[2]), .period_cnt(pc[2]));

  typedef struct {
    int         cyc;
    int         id;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic [3:0] pc;
  } exp_t;

  exp_t sb[$];
  int   ecount = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) ecount++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic push(input int c, input int id, input int qv, input int b, input int d, input int p);
    exp_t e;
    e.cyc  = c;
    e.id   = id;
    e.q    = qv[3:0];
    e.busy = (b != 0);
    e.done = (d != 0);
    e.pc   = PC_ON ? p[3:0] : 4'd0;
    sb.push_back(e);
  endtask

  // Expected trace of a one-shot run accepted at edge k: hold sampled high on edges
  // k+hs .. k+hs+hn-1, stop sampled on edge k+sj (sj<0: none).
  task automatic push_run(input int id, input int k, input int l, input int d,
                          input int hs, input int hn, input int sj);
    int t;
    int a;
    int qp;
    t  = (l + 1) * d;
    a  = 0;
    qp = 0;
    push(k, id, 0, 1, 0, 0);
    for (int j = 1; j < 1000; j++) begin
      if (j == sj) begin
        push(k + j, id, qp, 0, 0, 0);
        push(k + j + 1, id, qp, 0, 0, 0);
        break;
      end
      if (!(j >= hs && j < hs + hn)) a++;
      if (a == t) begin
        push(k + j, id, l, 0, 1, 1);
        push(k + j + 1, id, l, 0, 0, 1);
        break;
      end
      qp = a / d;
      push(k + j, id, qp, 1, 0, 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_start(input int id, input int l, input int p, output int k);
    st[id]  = 1'b1;
    lim[id] = l[W-1:0];
    per[id] = (p != 0);
    k       = ecount + 1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= ecount) begin
      e = sb.pop_front();
      if (e.cyc < ecount) begin
        check($sformatf("stale_entry_id%0d", e.id), 32'(e.cyc), 32'(ecount));
      end else begin
        check($sformatf("q_id%0d_e%0d", e.id, e.cyc),    32'(qo[e.id]), 32'(e.q));
        check($sformatf("busy_id%0d_e%0d", e.id, e.cyc), 32'(bz[e.id]), 32'(e.busy));
        check($sformatf("done_id%0d_e%0d", e.id, e.cyc), 32'(dn[e.id]), 32'(e.done));
        check($sformatf("pcnt_id%0d_e%0d", e.id, e.cyc), 32'(pc[e.id]), 32'(e.pc));
      end
    end
  end

  initial begin
    int k;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; sp[i] = 1'b0; hd[i] = 1'b0; per[i] = 1'b0; lim[i] = '0;
    end
    rst = 1'b1;
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_q_id%0d", i),    32'(qo[i]), 32'd0);
      check($sformatf("rst_busy_id%0d", i), 32'(bz[i]), 32'd0);
      check($sformatf("rst_done_id%0d", i), 32'(dn[i]), 32'd0);
      check($sformatf("rst_pcnt_id%0d", i), 32'(pc[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    step();

    // One-shot limit=3 DIV=2, with a start/limit change while busy that must be ignored.
    begin_start(0, 3, 0, k);
    push_run(0, k, 3, 2, 0, 0, -1);
    step();
    st[0] = 1'b0;
    repeat (2) step();
    st[0] = 1'b1; lim[0] = 4'd1;
    step();
    st[0] = 1'b0; lim[0] = 4'd3;
    repeat (8) step();

    // Five hold cycles mid-run push the terminal out by five edges.
    begin_start(0, 5, 0, k);
    push_run(0, k, 5, 2, 3, 5, -1);
    step();
    st[0] = 1'b0;
    repeat (2) step();
    hd[0] = 1'b1;
    repeat (5) step();
    hd[0] = 1'b0;
    repeat (12) step();

    // Stop on the terminal edge: no done, q keeps its value.
    begin_start(0, 2, 0, k);
    push_run(0, k, 2, 2, 0, 0, 6);
    step();
    st[0] = 1'b0;
    repeat (5) step();
    sp[0] = 1'b1;
    step();
    sp[0] = 1'b0;
    repeat (3) step();

    // limit=0 with DIV=3 terminates on the first tick.
    begin_start(2, 0, 0, k);
    push_run(2, k, 0, 3, 0, 0, -1);
    step();
    st[2] = 1'b0;
    repeat (5) step();

    // Periodic DIV=1 limit=2: period_cnt saturates at 15; ignored when the feature is off.
    begin_start(1, 2, 1, k);
`ifdef PERIODIC_EN
    for (int j = 0; j <= 50; j++) begin
      push(k + j, 1, j % 3, 1, (j > 0 && j % 3 == 0) ? 1 : 0, (j / 3 > 15) ? 15 : j / 3);
    end
    push(k + 51, 1, 2, 0, 0, 15);
    push(k + 52, 1, 2, 0, 0, 15);
    step();
    st[1] = 1'b0;
    repeat (50) step();
    sp[1] = 1'b1;
    step();
    sp[1] = 1'b0;
    repeat (3) step();
`else
    push_run(1, k, 2, 1, 0, 0, -1);
    step();
    st[1] = 1'b0; per[1] = 1'b0;
    repeat (6) step();
`endif

    // Asynchronous reset between edges mid-run, then a clean restart.
    begin_start(0, 7, 0, k);
    for (int j = 0; j <= 3; j++) push(k + j, 0, j / 2, 1, 0, 0);
    step();
    st[0] = 1'b0;
    repeat (3) step();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_q",    32'(qo[0]), 32'd0);
    check("arst_busy", 32'(bz[0]), 32'd0);
    check("arst_done", 32'(dn[0]), 32'd0);
    check("arst_pcnt", 32'(pc[0]), 32'd0);
    #1;
    rst = 1'b0;
    step();
    begin_start(0, 1, 0, k);
    push_run(0, k, 1, 2, 0, 0, -1);
    step();
    st[0] = 1'b0;
    repeat (6) step();

    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Controller that sequences a WIDTH-bit up-counter datapath: latches a terminal value, runs the count from a prescaled tick, supports pause, abort and optional periodic auto-restart, and reports completion with a busy/done handshake. It sits between a host control path (start/stop/hold) and the counter value consumers, replacing free-running ripple-style counters where deterministic, cycle-accurate sequencing is required.

## Interface
- WIDTH, 4, counter and limit width (≥1)
- DIV, 2, prescale divisor; one count tick every DIV active RUN cycles (≥1)

- clk  in  1  single clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a count; sampled only in IDLE
- stop  in  1  abort; returns to IDLE, highest priority
- hold  in  1  pause count and prescaler while high
- limit  in  WIDTH  terminal value, latched on accepted start
- periodic  in  1  auto-restart mode, latched on accepted start
- q  out  WIDTH  current count
- busy  out  1  high in RUN and PAUSE
- done  out  1  one-cycle pulse per completed period
- period_cnt  out  4  completed periods since start, saturates at 15

## Operation
- Reset (async): state IDLE, q=0, busy=0, done=0, prescaler=0, period_cnt=0, latched limit/periodic=0.
- States: IDLE, RUN, PAUSE.
- IDLE: start=1 and stop=0 → RUN; q←0, prescaler←0, period_cnt←0, limit/periodic latched. Otherwise q holds.
- RUN: hold=1 → PAUSE (no tick that cycle). Else prescaler increments; at prescaler==DIV-1 it wraps to 0 and a tick occurs.
- Tick with q<limit: q←q+1.
- Tick with q==limit (terminal): done=1 next cycle, period_cnt+1 (saturating). One-shot: → IDLE, q holds limit, busy←0. Periodic: stay RUN, q←0.
- Period = (limit+1)·DIV active cycles; limit=0 terminates on first tick.
- PAUSE: q and prescaler frozen; hold=0 → RUN, counting resumes with prescaler value preserved.
- stop=1 in RUN/PAUSE: → IDLE next edge, q holds, no done pulse; wins over terminal tick and hold in the same cycle.
- start while busy ignored; limit/periodic changes while busy ignored.
- done pulses never last more than one cycle; back-to-back only when DIV=1 and limit=0 (periodic).

## Timing
- start accepted at edge k: busy=1, q=0 from k.
- First increment at edge k+DIV; terminal tick at edge k+(limit+1)·DIV.
- done, busy fall (one-shot), q wrap (periodic), period_cnt update all registered on the terminal edge; no combinational path input→output.
- Each cycle of hold in RUN/PAUSE delays subsequent events by exactly one cycle.
- rst assertion mid-operation forces reset values immediately, independent of clk.

## Configuration
- PERIODIC_EN defined: periodic mode and period_cnt as described.
- Not defined: periodic input ignored (treated 0), every run is one-shot, period_cnt tied to 0 (port retained).

## Structure
- Package count_seq_pkg: state enum typedef (IDLE, RUN, PAUSE), period_cnt width constant (4) and saturation value (15).
- Sub-module tick_prescaler: DIV-modulo counter with clear and enable, outputs one-cycle tick; the FSM and count register stay in count_sequencer.

## Test plan
- One-shot, WIDTH=4, DIV=2, limit=3, start at edge 0 → q=1,2,3 at edges 2,4,6; terminal at edge 8: done=1 one cycle, busy=0, q stays 3, period_cnt=1.
- Periodic (PERIODIC_EN), DIV=1, limit=2 → q cycles 0,1,2,0…, done every 3 cycles; period_cnt reaches 15 after 15 periods and stays 15.
- hold high 5 cycles mid-run (DIV=2, limit=5) → q and prescaler frozen, busy=1, terminal delayed exactly 5 cycles.
- stop asserted on the same cycle as the terminal tick → IDLE, no done pulse, q holds pre-terminal value; start re-asserted during busy → ignored.
- limit=0, DIV=3 → done one cycle after edge 3, q=0, busy low after it.
- rst asserted asynchronously between edges mid-run → q=0, busy=0, done=0 immediately; next start runs normally from 0.
